// File: rtl/oka_pkg.sv
// Shared state encoding and coefficient-shuffling helpers for the folded
// overlap-free Karatsuba GF(2)[x] multiplier.
package oka_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {IDLE, M0, M1, M2, DONE} oka_state_e;

  function automatic int half_width(input int n);
    return (n + 1) / 2;
  endfunction

  // Coefficient i moves to position 2i, i.e. p(x) -> p(x^2) over GF(2).
  function automatic logic [2*MAX_W-1:0] spread(input logic [MAX_W-1:0] v);
    logic [2*MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[2*i] = v[i];
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] even_bits(input logic [2*MAX_W-1:0] v);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = v[2*i];
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] odd_bits(input logic [2*MAX_W-1:0] v);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = v[2*i+1];
    return r;
  endfunction

endpackage

// File: rtl/gf2_schoolbook_mult.sv
// Combinational carry-free schoolbook multiplier: p = a*b over GF(2)[x].
module gf2_schoolbook_mult #(
  parameter int W = 9
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-2:0] p_o
);

  always_comb begin
    p_o = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        p_o[i+j] = p_o[i+j] ^ (a_i[i] & b_i[j]);
      end
    end
  end

endmodule

// File: rtl/oka_folded_mult.sv
// Sequential overlap-free Karatsuba GF(2)[x] multiplier: one half-width
// sub-multiplier is reused for the three partial products over M0..M2.
module oka_folded_mult
  import oka_pkg::*;
#(
  parameter int N = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y
);

  localparam int H  = half_width(N);
  localparam int PW = 2*H - 1;

  oka_state_e state_q, state_d;
  logic [H-1:0]   aEven_q, aEven_d, aOdd_q, aOdd_d;
  logic [H-1:0]   bEven_q, bEven_d, bOdd_q, bOdd_d;
  logic [PW-1:0]  p0_q, p0_d, p1_q, p1_d;
  logic [2*N-2:0] y_q, y_d;

  logic [H-1:0]         mulA, mulB;
  logic [PW-1:0]        mulP;
  logic [PW-1:0]        pMid;
  logic [2*MAX_W-1:0]   aExt, bExt;
  logic [MAX_W-1:0]     aEvFull, aOdFull, bEvFull, bOdFull;
  logic [2*MAX_W-1:0]   prodFull;
  logic                 unusedBits;

  // Zero-extension past bit N-1 provides the MSB padding of the odd half.
  assign aExt    = {{(2*MAX_W-N){1'b0}}, a};
  assign bExt    = {{(2*MAX_W-N){1'b0}}, b};
  assign aEvFull = even_bits(aExt);
  assign aOdFull = odd_bits(aExt);
  assign bEvFull = even_bits(bExt);
  assign bOdFull = odd_bits(bExt);

  always_comb begin
    mulA = '0;
    mulB = '0;
    case (state_q)
      M0: begin mulA = aEven_q;           mulB = bEven_q;           end
      M1: begin mulA = aOdd_q;            mulB = bOdd_q;            end
      M2: begin mulA = aEven_q ^ aOdd_q;  mulB = bEven_q ^ bOdd_q;  end
      default: ;
    endcase
  end

  gf2_schoolbook_mult #(.W(H)) uMul (
    .a_i (mulA),
    .b_i (mulB),
    .p_o (mulP)
  );

  // During M2 mulP is P2, so the middle term P0^P1^P2 is available unregistered.
  assign pMid     = p0_q ^ p1_q ^ mulP;
  assign prodFull = spread({{(MAX_W-PW){1'b0}}, p0_q})
                  ^ (spread({{(MAX_W-PW){1'b0}}, pMid}) << 1)
                  ^ (spread({{(MAX_W-PW){1'b0}}, p1_q}) << 2);

  assign unusedBits = ^{prodFull, aEvFull, aOdFull, bEvFull, bOdFull};

  always_comb begin
    state_d = state_q;
    aEven_d = aEven_q;
    aOdd_d  = aOdd_q;
    bEven_d = bEven_q;
    bOdd_d  = bOdd_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aEven_d = aEvFull[H-1:0];
          aOdd_d  = aOdFull[H-1:0];
          bEven_d = bEvFull[H-1:0];
          bOdd_d  = bOdFull[H-1:0];
          state_d = M0;
        end
      end
      M0: begin p0_d = mulP; state_d = M1; end
      M1: begin p1_d = mulP; state_d = M2; end
      M2: begin y_d = prodFull[2*N-2:0]; state_d = DONE; end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aEven_q <= '0;
      aOdd_q  <= '0;
      bEven_q <= '0;
      bOdd_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      aEven_q <= aEven_d;
      aOdd_q  <= aOdd_d;
      bEven_q <= bEven_d;
      bOdd_q  <= bOdd_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_oka_folded_mult.sv
// Bench for oka_folded_mult: directed table at N=17, handshake corner
// sequences, then a random sweep at N=4 and N=17 against a bit-serial model.
module tb_oka_folded_mult;
  import oka_pkg::*;

  localparam int N   = 17;
  localparam int YW  = 2*N - 1;
  localparam int N4  = 4;
  localparam int YW4 = 2*N4 - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          inValid, inReady, outValid, outReady;
  logic [N-1:0]  a, b;
  logic [YW-1:0] y;

  logic           iv4, ir4, ov4, or4;
  logic [N4-1:0]  a4, b4;
  logic [YW4-1:0] y4;

  oka_folded_mult #(.N(N)) dutD (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .out_valid(outValid), .out_ready(outReady), .y(y)
  );

  oka_folded_mult #(.N(N4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .y(y4)
  );

  int nVec = 0;
  int nErr = 0;
  logic [YW-1:0] sbq[$];

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [YW-1:0] y;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [63:0] clmulRef(input logic [31:0] x, input logic [31:0] z);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (z[i]) r = r ^ ({32'b0, x} << i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepts one operand pair, queues its expected product and counts edges to out_valid.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic [YW-1:0] ev, output int lat);
    int guard;
    guard = 0;
    while (!inReady && guard < 50) begin @(posedge clk); #1; guard++; end
    checkOutput("in_ready_before_accept", 64'(inReady), 64'(1));
    a = av; b = bv; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    sbq.push_back(ev);
    lat = 0;
    while (!outValid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drainOne(input string name);
    logic [YW-1:0] ev;
    checkOutput({name, "_out_valid"}, 64'(outValid), 64'(1));
    checkOutput({name, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'(1));
    if (outValid && sbq.size() > 0) begin
      ev = sbq.pop_front();
      checkOutput({name, "_y"}, 64'(y), 64'(ev));
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput({name, "_valid_drop"}, 64'(outValid), 64'(0));
      checkOutput({name, "_in_ready"}, 64'(inReady), 64'(1));
    end
  endtask

  initial begin
    int lat;
    logic [YW-1:0] ev;
    logic [YW4-1:0] q4[$];
    logic [YW-1:0]  q17[$];
    int acc4, acc17, cyc;

    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0; a = '0; b = '0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    #2;
    checkOutput("reset_in_ready", 64'(inReady), 64'(1));
    checkOutput("reset_out_valid", 64'(outValid), 64'(0));
    checkOutput("reset_y", 64'(y), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{17'h00001, 17'h00001, 33'h0_0000_0001};
    vecs[1] = '{17'h10000, 17'h10000, 33'h1_0000_0000};
    vecs[2] = '{17'h00003, 17'h00003, 33'h0_0000_0005};
    vecs[3] = '{17'h1FFFF, 17'h00001, 33'h0_0001_FFFF};
    vecs[4] = '{17'h1FFFF, 17'h1FFFF, 33'h1_5555_5555};
    vecs[5] = '{17'h00005, 17'h00003, 33'h0_0000_000F};
    vecs[6] = '{17'h00000, 17'h1ABCD, 33'h0_0000_0000};
    vecs[7] = '{17'h10001, 17'h00002, 33'h0_0002_0002};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].y, lat);
      checkOutput($sformatf("latency_%0d", i), 64'(lat), 64'(3));
      drainOne($sformatf("vec_%0d", i));
    end

    // Idle with in_valid low: nothing may start.
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("idle_out_valid", 64'(outValid), 64'(0));
      checkOutput("idle_in_ready", 64'(inReady), 64'(1));
    end

    // Backpressure: result held, new operands refused, no accept in DONE.
    applyStimulus(17'h3, 17'h3, 33'h5, lat);
    checkOutput("bp_latency", 64'(lat), 64'(3));
    ev = sbq.pop_front();
    a = 17'h7; b = 17'h7; inValid = 1'b1; outReady = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checkOutput("bp_y_stable", 64'(y), 64'(ev));
      checkOutput("bp_out_valid", 64'(outValid), 64'(1));
      checkOutput("bp_in_ready", 64'(inReady), 64'(0));
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0; inValid = 1'b0;
    checkOutput("bp_release_valid", 64'(outValid), 64'(0));
    checkOutput("bp_release_ready", 64'(inReady), 64'(1));
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("bp_no_ghost", 64'(outValid), 64'(0));
    end

    // Reset while in M1: in-flight product discarded.
    a = 17'h1FFFF; b = 17'h1FFFF; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_reset_state_m1", 64'(dutD.state_q == M1), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(outValid), 64'(0));
    checkOutput("midreset_in_ready", 64'(inReady), 64'(1));
    checkOutput("midreset_y", 64'(y), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("midreset_no_output", 64'(outValid), 64'(0));
    end
    applyStimulus(17'h3, 17'h3, 33'h5, lat);
    checkOutput("post_reset_latency", 64'(lat), 64'(3));
    drainOne("post_reset");

    // Random sweep on both widths, driven on the falling edge.
    acc4 = 0; acc17 = 0; cyc = 0;
    while ((acc4 < 1000 || acc17 < 1000 || q4.size() > 0 || q17.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      iv4      = (acc4 < 1000) && ($urandom_range(0, 3) != 0);
      a4       = N4'($urandom);
      b4       = N4'($urandom);
      or4      = ($urandom_range(0, 3) != 0);
      inValid  = (acc17 < 1000) && ($urandom_range(0, 3) != 0);
      a        = N'($urandom);
      b        = N'($urandom);
      outReady = ($urandom_range(0, 3) != 0);
      if (iv4 && ir4) begin
        q4.push_back(YW4'(clmulRef(32'(a4), 32'(b4))));
        acc4++;
      end
      if (inValid && inReady) begin
        q17.push_back(YW'(clmulRef(32'(a), 32'(b))));
        acc17++;
      end
      if (ov4 && or4) begin
        checkOutput("sweep4_sb_nonempty", 64'(q4.size() > 0), 64'(1));
        if (q4.size() > 0) checkOutput("sweep4_y", 64'(y4), 64'(q4.pop_front()));
      end
      if (outValid && outReady) begin
        checkOutput("sweep17_sb_nonempty", 64'(q17.size() > 0), 64'(1));
        if (q17.size() > 0) checkOutput("sweep17_y", 64'(y), 64'(q17.pop_front()));
      end
      if (dutD.state_q == M2)
        checkOutput("sweep17_upper_bits_zero", 64'(|(dutD.prodFull >> YW)), 64'(0));
      if (dut4.state_q == M2)
        checkOutput("sweep4_upper_bits_zero", 64'(|(dut4.prodFull >> YW4)), 64'(0));
    end
    iv4 = 1'b0; or4 = 1'b0; inValid = 1'b0; outReady = 1'b0;
    checkOutput("sweep4_accepted", 64'(acc4), 64'(1000));
    checkOutput("sweep17_accepted", 64'(acc17), 64'(1000));
    checkOutput("sweep4_drained", 64'(q4.size()), 64'(0));
    checkOutput("sweep17_drained", 64'(q17.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/oka_folded_mult.md
Name: oka_folded_mult

Overview:
- Parametrised, sequential successor of the fixed-width combinational overlap-free Karatsuba (OKA) GF(2)[x] polynomial multiplier.
- Splits both N-bit operands into even and odd coefficient halves of width H.
- Reuses one H-bit schoolbook sub-multiplier over three cycles instead of instantiating three, trading latency for area.
- Sits in the OBS multiplier datapath ahead of field reduction, with valid/ready handshakes on both sides.

Parameters:
- N, 17, operand width in coefficients; legal range N >= 3, odd or even.
- H, (N+1)/2, half width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  N  operand A, bit i = coefficient of x^i
- b  in  N  operand B, same encoding as a
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- y  out  2N-1  product A·B over GF(2), unreduced

Behaviour:
- Reset (async assert, sync release) forces the following values:
  - state = IDLE, in_ready = 1, out_valid = 0, y = 0.
  - Operand and partial-product registers = 0.
- FSM states: IDLE -> M0 -> M1 -> M2 -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register the split operands and go to M0:
    - Ae/Be = even coefficients (bits 0, 2, 4, …).
    - Ao/Bo = odd coefficients (bits 1, 3, …), zero-padded at the MSB when N is odd.
- M0: shared sub-multiplier computes P0 = Ae·Be (2H-1 bits) into register; go to M1.
- M1: P1 = Ao·Bo; go to M2.
- M2: P2 = (Ae^Ao)·(Be^Bo). In the same cycle, load y with the recombination below; go to DONE.
- Recombination: y = S(P0) ^ (S(P0^P1^P2) << 1) ^ (S(P1) << 2), truncated to 2N-1 bits.
  - S() spreads coefficient i to position 2i.
  - Bits above 2N-2 are zero by construction; the testbench asserts this.
- DONE:
  - out_valid = 1; y held stable.
  - On out_ready go to IDLE; out_valid drops the next cycle.
- Latency: accept edge k -> out_valid high after edge k+3. Minimum issue interval is 5 cycles with out_ready tied high.
- in_ready is 0 in every state except IDLE. No accept in DONE, even when out_ready = 1 in the same cycle.
- out_valid must not depend combinationally on out_ready. y changes only on the M2 -> DONE edge.
- in_valid deasserted in IDLE: the block stays idle and the operand registers hold.
- Reset asserted mid-operation (any of M0–DONE): immediate return to reset values; the in-flight product is discarded with no output.
- All arithmetic is carry-free XOR/AND; no integer carries anywhere.

Decomposition:
- Shared package oka_pkg holds:
  - State enum (IDLE, M0, M1, M2, DONE).
  - Function half_width(N).
  - Function spread(vec) for zero-interleaving.
  - Functions even_bits / odd_bits for coefficient extraction.
- One natural sub-module: gf2_schoolbook_mult. Combinational, parameter W = H, inputs W bits, output 2W-1 bits. Instantiated once and muxed per state.
- Recombination stays inline in oka_folded_mult.

Test Plan:
- N=17, a=0x00001, b=0x00001 -> y=0x1; out_valid 3 cycles after accept.
- N=17, a=0x10000, b=0x10000 -> y=0x1_0000_0000 (x^32 only).
- N=17, a=0x00003, b=0x00003 -> y=0x5 ((x+1)^2 = x^2+1). Then a=0x1FFFF, b=0x00001 -> y=0x1FFFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - y and out_valid stay stable; in_ready stays 0; a new in_valid is ignored.
  - On release, out_valid drops the next cycle and in_ready=1.
- Reset mid-M1: pulse rst_n low for 1 cycle.
  - out_valid=0, in_ready=1, y=0 immediately.
  - The next accepted operand pair a=0x3, b=0x3 yields y=0x5.
- Parametric sweep: N=4 (even) and N=17, 1000 random pairs each with random in_valid/out_ready.
  - Every y matches a bit-serial GF(2) reference model.
  - No accepted operand is lost or duplicated.
